// File: rtl/acq_sequencer_if.sv
// RAM port and readout stream between acq_sequencer (master) and the SPRAM
// store / downstream sink (slave).
interface acq_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int BANK_W = 2
);
    logic              ram_we;
    logic              ram_re;
    logic [BANK_W-1:0] ram_bank;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output ram_we, ram_re, ram_bank, ram_addr, ram_wdata, tx_valid, tx_data,
        input  ram_rdata, tx_ready
    );

    modport slave (
        input  ram_we, ram_re, ram_bank, ram_addr, ram_wdata, tx_valid, tx_data,
        output ram_rdata, tx_ready
    );
endinterface

// File: rtl/acq_sequencer.sv
// Button-driven acquisition sequencer: captures ADC samples into a banked
// SPRAM store and replays them over a valid/ready stream.
//
// state    | meaning
// IDLE     | waiting for start (capture) or read (replay) pulse
// CAPTURE  | writing each sample_valid word at the write pointer
// RD_ISSUE | ram_re high for the word at the read pointer
// RD_WAIT  | SPRAM output settling, latched into tx_data at end of cycle
// RD_SEND  | tx_valid held until tx_ready, then next word or done
module acq_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int BANK_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_once,
    input  logic                   stop_once,
    input  logic                   read_once,
    input  logic                   sample_valid,
    input  logic [DATA_W-1:0]      sample_data,
    acq_sequencer_if.master        bus,
    output logic                   busy,
    output logic                   full,
    output logic [ADDR_W+BANK_W:0] count,
    output logic                   done
);
    localparam int PTR_W = ADDR_W + BANK_W;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LAST_PTR = {PTR_W{1'b1}};

    typedef enum logic [2:0] {IDLE, CAPTURE, RD_ISSUE, RD_WAIT, RD_SEND} state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   last_rd;

    assign rd_next = rd_ptr + PTR_ONE;
    assign last_rd = count - CNT_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            full          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_re    <= 1'b0;
            bus.ram_bank  <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= '0;
        end else begin
            bus.ram_we <= 1'b0;
            bus.ram_re <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    // stop outranks start, which outranks read
                    if (!stop_once) begin
                        if (start_once) begin
                            wr_ptr <= '0;
                            count  <= '0;
                            full   <= 1'b0;
                            state  <= CAPTURE;
                            busy   <= 1'b1;
                        end else if (read_once && count != '0) begin
                            rd_ptr                      <= '0;
                            {bus.ram_bank, bus.ram_addr} <= '0;
                            bus.ram_re                  <= 1'b1;
                            state                       <= RD_ISSUE;
                            busy                        <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        bus.ram_we                  <= 1'b1;
                        bus.ram_wdata               <= sample_data;
                        {bus.ram_bank, bus.ram_addr} <= wr_ptr;
                        wr_ptr                      <= wr_ptr + PTR_ONE;
                        count                       <= count + CNT_ONE;
                        if (wr_ptr == LAST_PTR) begin
                            full  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    if (stop_once) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    if (stop_once) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (stop_once) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        bus.tx_data  <= bus.ram_rdata;
                        bus.tx_valid <= 1'b1;
                        state        <= RD_SEND;
                    end
                end
                RD_SEND: begin
                    if (stop_once) begin
                        bus.tx_valid <= 1'b0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end else if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if ({1'b0, rd_ptr} == last_rd) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            rd_ptr                      <= rd_next;
                            {bus.ram_bank, bus.ram_addr} <= rd_next;
                            bus.ram_re                  <= 1'b1;
                            state                       <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acq_sequencer.sv
// Randomised directed bench for acq_sequencer in a small DEPTH=8 configuration,
// checked against a queue-based model of the sample store.
module tb_acq_sequencer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;
    localparam int BANK_W = 1;
    localparam int DEPTH  = 1 << (ADDR_W + BANK_W);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start_once, stop_once, read_once, sample_valid;
    logic [DATA_W-1:0]      sample_data;
    logic                   busy, full, done;
    logic [ADDR_W+BANK_W:0] count;

    acq_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

    acq_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
        .clk(clk), .reset(reset), .start_once(start_once), .stop_once(stop_once),
        .read_once(read_once), .sample_valid(sample_valid), .sample_data(sample_data),
        .bus(bus), .busy(busy), .full(full), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural SPRAM: one-cycle read latency
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[{bus.ram_bank, bus.ram_addr}] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[{bus.ram_bank, bus.ram_addr}];
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] stored [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_we"}, bus.ram_we, 0);
        check({tag, "_re"}, bus.ram_re, 0);
        check({tag, "_ptr"}, {bus.ram_bank, bus.ram_addr}, 0);
        check({tag, "_wdata"}, bus.ram_wdata, 0);
        check({tag, "_txv"}, bus.tx_valid, 0);
        check({tag, "_txd"}, bus.tx_data, 0);
    endtask

    task automatic do_capture(input int n, input bit gaps, input bit stop_with_last,
                              input bit seq_data, input logic [DATA_W-1:0] base);
        int offered;
        logic [DATA_W-1:0] d;
        bit v;
        offered = 0;
        start_once = 1'b1;
        step();
        start_once = 1'b0;
        stored.delete();
        check("busy_after_start", busy, 1);
        while (offered < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = seq_data ? DATA_W'(base + offered) : DATA_W'($urandom());
            sample_valid = v;
            sample_data  = d;
            stop_once    = stop_with_last && v && (offered == n - 1);
            step();
            sample_valid = 1'b0;
            stop_once    = 1'b0;
            if (v) begin
                if (stored.size() < DEPTH) begin
                    check("wr_en", bus.ram_we, 1);
                    check("wr_data", bus.ram_wdata, d);
                    check("wr_ptr", {bus.ram_bank, bus.ram_addr}, stored.size());
                    stored.push_back(d);
                    if (stored.size() == DEPTH) check("busy_at_full", busy, 0);
                end else begin
                    check("wr_after_full", bus.ram_we, 0);
                end
                offered++;
            end else begin
                check("wr_gap", bus.ram_we, 0);
            end
        end
        if (!stop_with_last && stored.size() < DEPTH) begin
            stop_once = 1'b1;
            step();
            stop_once = 1'b0;
            check("wr_on_stop", bus.ram_we, 0);
        end
        check("busy_after_capture", busy, 0);
        check("count_after_capture", count, stored.size());
        check("full_after_capture", full, stored.size() == DEPTH);
    endtask

    // ready_mode: 0 always high, 1 toggling 1/0, 2 random; stop_at = word index to abort on (-1 none)
    task automatic do_readout(input int ready_mode, input int stop_at);
        int k, dones, res, cyc;
        bit hold, fin, r;
        logic [DATA_W-1:0] held;
        k = 0; dones = 0; res = 0; cyc = 0; hold = 0; fin = 0; held = '0;
        read_once = 1'b1;
        step();
        read_once = 1'b0;
        if (stored.size() == 0) begin
            for (int i = 0; i < 3; i++) begin
                check("empty_read_re", bus.ram_re, 0);
                check("empty_read_busy", busy, 0);
                step();
            end
            return;
        end
        check("re_after_read", bus.ram_re, 1);
        check("busy_after_read", busy, 1);
        check("first_rd_ptr", {bus.ram_bank, bus.ram_addr}, 0);
        while (!fin && cyc < 40 * DEPTH) begin
            if (bus.tx_valid && stop_at == k) begin
                stop_once = 1'b1;
                bus.tx_ready = 1'b0;
                step();
                stop_once = 1'b0;
                check("stop_txv", bus.tx_valid, 0);
                for (int i = 0; i < 3; i++) begin
                    check("stop_done", done, 0);
                    check("stop_busy", busy, 0);
                    step();
                end
                return;
            end
            r = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.tx_ready = r;
            if (bus.tx_valid && r) begin
                if (k < stored.size()) check("tx_data", bus.tx_data, stored[k]);
                else check("extra_word", k, stored.size());
                k++;
            end
            hold = bus.tx_valid && !r;
            held = bus.tx_data;
            step();
            cyc++;
            bus.tx_ready = 1'b0;
            if (bus.ram_re) res++;
            if (hold) begin
                check("hold_valid", bus.tx_valid, 1);
                check("hold_data", bus.tx_data, held);
            end
            if (done) begin
                dones++;
                fin = 1'b1;
                check("busy_with_done", busy, 0);
                check("words_at_done", k, stored.size());
            end
        end
        check("read_finished", fin, 1);
        check("ram_re_pulses", res + 1, stored.size());
        if (ready_mode == 0) check("cycles_per_word", cyc, 3 * stored.size());
        step();
        check("done_single_cycle", done, 0);
        check("count_after_read", count, stored.size());
        check("full_after_read", full, stored.size() == DEPTH);
        check("done_count", dones, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_once = 1'b0; stop_once = 1'b0; read_once = 1'b0;
        sample_valid = 1'b0; sample_data = '0; bus.tx_ready = 1'b0;
        step();
        step();
        check_cleared("reset");
        reset = 1'b0;
        step();

        do_readout(0, -1);

        do_capture(5, 1'b0, 1'b0, 1'b1, 16'h0011);
        do_readout(1, -1);
        do_readout(0, -1);

        // start and stop together in IDLE: nothing happens, store untouched
        start_once = 1'b1; stop_once = 1'b1;
        step();
        start_once = 1'b0; stop_once = 1'b0;
        check("start_stop_busy", busy, 0);
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'hdead;
            step();
            sample_valid = 1'b0;
            check("start_stop_no_we", bus.ram_we, 0);
        end
        check("start_stop_count", count, 5);
        do_readout(2, -1);

        do_capture(6, 1'b1, 1'b1, 1'b0, '0);
        do_readout(2, -1);
        do_readout(2, 2);
        do_readout(0, -1);

        do_capture(10, 1'b0, 1'b0, 1'b0, '0);
        do_readout(2, -1);
        do_capture(12, 1'b1, 1'b0, 1'b0, '0);
        do_readout(1, -1);

        // reset in the middle of a capture
        start_once = 1'b1;
        step();
        start_once = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = DATA_W'($urandom());
            step();
        end
        sample_valid = 1'b0;
        reset = 1'b1;
        step();
        stored.delete();
        check_cleared("mid_reset");
        reset = 1'b0;
        step();
        do_readout(0, -1);
        do_capture(4, 1'b1, 1'b0, 1'b0, '0);
        do_readout(2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Button-driven acquisition controller sitting between the button conditioning (synchronised, debounced, one-shot pulses) and the multi-bank SPRAM sample store. It captures a stream of ADC samples into a linear address space spread across NUM_BANKS SPRAM banks on a start pulse. It stops on a stop pulse or when the store is full. On a read pulse it replays the captured words through a valid/ready output port.

## Interface
- DATA_W, 16, sample and RAM word width
- ADDR_W, 14, address width inside one SPRAM bank (2**ADDR_W words/bank)
- BANK_W, 2, bank-select width; NUM_BANKS = 2**BANK_W; DEPTH = 2**(ADDR_W+BANK_W)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_once  in  1  one-cycle pulse: begin capture
- stop_once  in  1  one-cycle pulse: end capture / abort readout
- read_once  in  1  one-cycle pulse: begin readout
- sample_valid  in  1  ADC sample strobe
- sample_data  in  DATA_W  ADC sample
- ram_we  out  1  write enable, registered
- ram_re  out  1  read enable, registered
- ram_bank  out  BANK_W  bank select = pointer[ADDR_W+BANK_W-1:ADDR_W]
- ram_addr  out  ADDR_W  in-bank address = pointer[ADDR_W-1:0]
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  SPRAM read data, valid 1 cycle after ram_re
- tx_valid  out  1  readout word valid
- tx_data  out  DATA_W  readout word
- tx_ready  in  1  downstream accepts word
- busy  out  1  high in any state other than IDLE
- full  out  1  store filled to DEPTH; sticky until next start
- count  out  ADDR_W+BANK_W+1  number of words captured (0..DEPTH)
- done  out  1  one-cycle pulse at end of readout

## Operation
- States: IDLE, CAPTURE, RD_ISSUE, RD_WAIT, RD_SEND.
- Pulse priority, same cycle: stop_once > start_once > read_once.
- IDLE:
  - start_once: clear wr pointer, count and full; go to CAPTURE.
  - read_once with count>0: clear rd pointer; go to RD_ISSUE.
  - read_once with count=0: ignored.
- CAPTURE, each sample_valid:
  - Next cycle ram_we=1, ram_wdata=sample_data, bank/addr=wr pointer.
  - wr pointer and count increment.
  - Writing address DEPTH-1 sets full=1 and returns to IDLE; no wrap-around, no overwrite.
- CAPTURE, stop_once:
  - Returns to IDLE.
  - A sample_valid in the same cycle is still written and counted.
- CAPTURE, start_once and read_once: ignored.
- RD_ISSUE: ram_re=1 for one cycle at rd pointer → RD_WAIT.
- RD_WAIT: capture ram_rdata into tx_data → RD_SEND.
- RD_SEND:
  - tx_valid=1 and tx_data held stable until tx_ready.
  - On handshake: if rd pointer = count-1, pulse done and go to IDLE; else increment rd pointer and go to RD_ISSUE.
- Any read state, stop_once: drop tx_valid; go to IDLE; no done pulse.
- Readout is non-destructive: count and full are unchanged, and a second read_once replays the same data.
- count width is ADDR_W+BANK_W+1 so that DEPTH is representable; pointers are ADDR_W+BANK_W bits.

## Timing
- Reset values: state IDLE; all pointers, count, full, ram_we, ram_re, ram_bank, ram_addr, ram_wdata, tx_valid, tx_data, busy and done are 0.
- Reset mid-capture or mid-readout takes effect next edge. Captured data is considered lost (count=0).
- Write latency: sample_valid at edge N → ram_we/addr/data valid during cycle N+1.
- Back-to-back sample_valid every cycle is sustained: one write per cycle.
- Read: ram_re in cycle N, ram_rdata sampled at the end of cycle N+1, tx_valid from cycle N+2.
- Minimum 3 cycles per word with tx_ready held high.
- busy rises the cycle after the start/read pulse and falls the cycle after the final write, stop, or final handshake.
- done is coincident with busy falling at the end of readout.

## Test plan
- Start, 5 samples (0x0011..0x0015), stop → ram_we at addr 0..4 bank 0, count=5, full=0, busy=0.
- Small config ADDR_W=2, BANK_W=1 (DEPTH 8), start, 10 continuous samples → writes to bank0 addr0-3, then bank1 addr0-3; full=1; count=8; samples 9-10 not written.
- Read after 5-sample capture with tx_ready toggling 1/0 → tx_data 0x0011..0x0015 in order, each held until tx_ready; done pulse once; second read replays identically.
- start_once and stop_once in same cycle in IDLE → stays IDLE; stop with sample_valid in the same cycle during CAPTURE → that sample written, count incremented.
- read_once with count=0 → no ram_re, busy stays 0; stop_once during RD_SEND → tx_valid drops next cycle, no done.
- reset asserted during CAPTURE after 3 samples → next cycle all outputs 0, count=0, state IDLE; subsequent start works normally.
